// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep controller: drives an external up/down counter between two
// captured bounds, counting completed down-strokes as laps.
module updown_sweep_ctrl #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned LAP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [LAP_W-1:0] lap_target,
  input  logic [WIDTH-1:0] count_in,
  output logic             preset,
  output logic             mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LAP_W-1:0] laps
);

  typedef enum logic [2:0] {StIdle, StLoad, StUp, StDown, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [LAP_W-1:0]   tgt_q, tgt_d;
  logic [LAP_W-1:0]   laps_q, laps_d;
  logic [LAP_W-1:0]   laps_inc;
  logic               preset_q, preset_d;
  logic               mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Next-state logic; outputs are decoded from the next state so that the
  // registered outputs always describe the state currently held.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    tgt_d    = tgt_q;
    laps_d   = laps_q;
    err_d    = 1'b0;
    // Saturating increment: laps never wraps back to zero.
    laps_inc = (laps_q == {LAP_W{1'b1}}) ? laps_q : laps_q + LAP_W'(1);

    unique case (state_q)
      StIdle: begin
        // stop has priority over start, and suppresses the reject pulse too.
        if (start && !stop) begin
          if (lo < hi) begin
            state_d = StLoad;
            laps_d  = '0;
            lo_d    = lo;
            hi_d    = hi;
            tgt_d   = lap_target;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        state_d = stop ? StIdle : StUp;
      end
      StUp: begin
        if (stop) begin
          state_d = StIdle;
        end else if (count_in == hi_q) begin
          state_d = StDown;
        end
      end
      StDown: begin
        if (stop) begin
          state_d = StIdle;
        end else if (count_in == lo_q) begin
          laps_d  = laps_inc;
          state_d = ((tgt_q != '0) && (laps_inc == tgt_q)) ? StDone : StUp;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    preset_d = (state_d == StLoad);
    mode_d   = (state_d == StDown);
    busy_d   = (state_d == StLoad) || (state_d == StUp) || (state_d == StDown);
    done_d   = (state_d == StDone);
  end

  // State, captured sweep parameters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= '0;
      tgt_q    <= '0;
      laps_q   <= '0;
      preset_q <= 1'b0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      tgt_q    <= tgt_d;
      laps_q   <= laps_d;
      preset_q <= preset_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign preset = preset_q;
  assign mode   = mode_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign laps   = laps_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl, with a behavioural up/down counter
// closing the count_in loop. A second instance with LAP_W=4 checks saturation.
module tb_updown_sweep_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic [4:0] lo;
  logic [4:0] hi;
  logic [7:0] lap_target;
  logic [4:0] cnt;
  logic [4:0] cnt4;

  logic       preset, mode, busy, done, err;
  logic [7:0] laps;
  logic       preset4, mode4, busy4, done4, err4;
  logic [3:0] laps4;

  int n_assert = 0;
  int n_fail   = 0;
  int done_seen;

  updown_sweep_ctrl #(.WIDTH(5), .LAP_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .lo         (lo),
    .hi         (hi),
    .lap_target (lap_target),
    .count_in   (cnt),
    .preset     (preset),
    .mode       (mode),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .laps       (laps)
  );

  updown_sweep_ctrl #(.WIDTH(5), .LAP_W(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .lo         (lo),
    .hi         (hi),
    .lap_target (lap_target[3:0]),
    .count_in   (cnt4),
    .preset     (preset4),
    .mode       (mode4),
    .busy       (busy4),
    .done       (done4),
    .err        (err4),
    .laps       (laps4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream counter models: load lo on preset, otherwise count while busy.
  initial begin
    cnt  = '0;
    cnt4 = '0;
  end
  always @(posedge clk) begin
    if (preset) cnt <= lo;
    else if (busy) cnt <= mode ? cnt - 5'd1 : cnt + 5'd1;
    if (preset4) cnt4 <= lo;
    else if (busy4) cnt4 <= mode4 ? cnt4 - 5'd1 : cnt4 + 5'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    lo = 5'd0; hi = 5'd0; lap_target = 8'd0;
    #1;
    chk("reset_outputs", {preset, mode, busy, done, err}, 5'b0);
    chk("reset_laps", laps, 0);
    #12;
    reset = 1'b1;
    step();

    // Basic sweep lo=2 hi=6 target=1.
    lo = 5'd2; hi = 5'd6; lap_target = 8'd1; start = 1'b1;
    step();
    chk("basic_load_preset", preset, 1);
    chk("basic_load_busy", busy, 1);
    chk("basic_load_mode", mode, 0);
    start = 1'b0;
    step();
    chk("basic_preset_one_cycle", preset, 0);
    chk("basic_count_loaded", cnt, 2);
    repeat (4) step();
    chk("basic_at_hi_count", cnt, 6);
    chk("basic_at_hi_mode", mode, 0);
    step();
    chk("basic_turn_mode", mode, 1);
    chk("basic_turn_busy", busy, 1);
    repeat (5) step();
    chk("basic_at_lo_count", cnt, 2);
    chk("basic_at_lo_done", done, 0);
    step();
    chk("basic_done", done, 1);
    chk("basic_done_laps", laps, 1);
    chk("basic_done_busy", busy, 0);
    chk("basic_done_mode", mode, 0);
    step();
    chk("basic_done_one_cycle", done, 0);

    // Reject lo >= hi.
    lo = 5'd9; hi = 5'd9; start = 1'b1;
    step();
    chk("reject_err", err, 1);
    chk("reject_busy", busy, 0);
    chk("reject_preset", preset, 0);
    start = 1'b0;
    step();
    chk("reject_err_one_cycle", err, 0);
    chk("reject_preset_after", preset, 0);

    // start and stop together in IDLE: stop wins, no err either way.
    lo = 5'd2; hi = 5'd6; start = 1'b1; stop = 1'b1;
    step();
    chk("both_valid_busy", busy, 0);
    chk("both_valid_preset", preset, 0);
    lo = 5'd9; hi = 5'd9;
    step();
    chk("both_reject_err", err, 0);
    start = 1'b0; stop = 1'b0;

    // Start during UP ignored; live bounds/target changes ignored.
    lo = 5'd2; hi = 5'd6; lap_target = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("ignore_count_loaded", cnt, 2);
    lo = 5'd0; hi = 5'd3; lap_target = 8'd5; start = 1'b1;
    step();
    chk("ignore_start_busy", busy, 1);
    chk("ignore_start_preset", preset, 0);
    start = 1'b0;
    repeat (3) step();
    chk("ignore_at_hi_count", cnt, 6);
    chk("ignore_at_hi_mode", mode, 0);
    step();
    chk("ignore_turn_mode", mode, 1);
    repeat (6) step();
    chk("ignore_done", done, 1);
    chk("ignore_laps", laps, 1);
    step();

    // Abort in UP at count 10.
    lo = 5'd0; hi = 5'd31; lap_target = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (10) step();
    chk("abort_count", cnt, 10);
    chk("abort_pre_mode", mode, 0);
    stop = 1'b1;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_mode", mode, 0);
    chk("abort_preset", preset, 0);
    chk("abort_laps", laps, 0);
    chk("abort_done", done, 0);
    stop = 1'b0;
    step();
    chk("abort_no_late_done", done, 0);

    // Free-run 20 laps, bounded wait.
    lo = 5'd0; hi = 5'd3; lap_target = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 600 && laps != 8'd20; i++) begin
      step();
      if (done || done4) done_seen++;
    end
    chk("freerun_laps", laps, 20);
    chk("freerun_laps_sat", laps4, 15);
    chk("freerun_no_done", done_seen, 0);
    chk("freerun_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("freerun_stop_laps", laps, 20);
    chk("freerun_stop_busy", busy, 0);

    // Asynchronous reset during DOWN.
    lo = 5'd2; hi = 5'd6; lap_target = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("areset_in_down", mode, 1);
    chk("areset_in_down_busy", busy, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("areset_outputs", {preset, mode, busy, done, err}, 5'b0);
    chk("areset_laps", laps, 0);
    #2;
    reset = 1'b1;
    lap_target = 8'd1; start = 1'b1;
    step();
    chk("first_start_busy", busy, 1);
    chk("first_start_preset", preset, 1);
    start = 1'b0; stop = 1'b1;
    step();
    chk("first_start_stop", busy, 0);
    stop = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 5: width of the count bus and bounds.
REQ-002 Parameter LAP_W, default 8: width of the lap target and lap counter.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: sweep request, sampled on clk.
REQ-006 The module SHALL have port stop, input, 1 bit: abort request, sampled on clk.
REQ-007 The module SHALL have port lo, input, WIDTH bits: lower turn-around bound.
REQ-008 The module SHALL have port hi, input, WIDTH bits: upper turn-around bound.
REQ-009 The module SHALL have port lap_target, input, LAP_W bits: laps to run; 0 = run until stop.
REQ-010 The module SHALL have port count_in, input, WIDTH bits: current value fed back from the downstream up/down counter.
REQ-011 The module SHALL have port preset, output, 1 bit: one-cycle load request to the counter.
REQ-012 The module SHALL have port mode, output, 1 bit: counter direction, 0 = up, 1 = down.
REQ-013 The module SHALL have port busy, output, 1 bit: high while a sweep is active.
REQ-014 The module SHALL have port done, output, 1 bit: one-cycle pulse when lap_target is reached.
REQ-015 The module SHALL have port err, output, 1 bit: one-cycle pulse when start is rejected.
REQ-016 The module SHALL have port laps, output, LAP_W bits: completed-lap count.

Function
REQ-017 The controller SHALL implement states IDLE, LOAD, UP, DOWN and DONE; all outputs SHALL be registered.
REQ-018 In IDLE with start=1, stop=0 and lo<hi, the next state SHALL be LOAD, laps SHALL clear to 0, and lo, hi and lap_target SHALL be captured into internal registers.
REQ-019 In IDLE with start=1 and lo>=hi, the controller SHALL stay in IDLE and pulse err for exactly 1 cycle.
REQ-020 In LOAD, preset SHALL be 1 for exactly 1 cycle and mode SHALL be 0; the next state SHALL be UP.
REQ-021 In UP, mode SHALL be 0; when count_in equals the captured hi, the next state SHALL be DOWN and mode SHALL be 1 from the following cycle.
REQ-022 In DOWN, mode SHALL be 1; when count_in equals the captured lo, laps SHALL increment and the next state SHALL be UP, or DONE if the captured target is nonzero and the incremented laps equals it.
REQ-023 Laps SHALL saturate at 2^LAP_W-1 and never wrap.
REQ-024 In DONE, done SHALL be 1 for exactly 1 cycle, mode SHALL be 0, and the next state SHALL be IDLE.
REQ-025 Busy SHALL be 1 in LOAD, UP and DOWN, and 0 in IDLE and DONE.
REQ-026 Stop=1 in LOAD, UP or DOWN SHALL force IDLE on the next edge with mode=0 and preset=0; laps SHALL be retained and done SHALL not pulse.
REQ-027 If start and stop are both 1 in IDLE, stop SHALL win: no transition and no err.
REQ-028 Start while busy SHALL be ignored.
REQ-029 Changes to lo, hi and lap_target during a sweep SHALL have no effect until the next start.
REQ-030 If count_in lies outside [lo, hi], the controller SHALL hold its direction until the bound is matched; no wrap correction is performed.

Reset
REQ-031 When reset=0, asynchronously: state SHALL be IDLE, preset=0, mode=0, busy=0, done=0, err=0, laps=0.
REQ-032 Reset asserted mid-sweep SHALL abort immediately with no done pulse.
REQ-033 After reset deasserts, the first start SHALL be honoured on the first rising edge.

Verification
REQ-034 Basic sweep: reset low then high, lo=2, hi=6, lap_target=1, start pulse, count_in driven by a model counter preset to 2 -> preset pulse 1 cycle, mode flips 0->1 the cycle after count_in=6, done pulses after count_in returns to 2, laps=1, busy low.
REQ-035 Reject: lo=9, hi=9, start -> err pulse of 1 cycle, busy stays 0, preset never asserted.
REQ-036 Abort: lo=0, hi=31, lap_target=0, stop asserted while count_in=10 in UP -> busy=0 and mode=0 next cycle, laps unchanged, no done pulse.
REQ-037 Free-run: lap_target=0, lo=0, hi=3 for 20 laps -> laps=20, done never pulses; with LAP_W=4 run 20 laps -> laps saturates at 15.
REQ-038 Asynchronous reset: reset driven low between clock edges during DOWN -> all outputs 0 immediately, before the next edge.
REQ-039 Simultaneous: start=1 and stop=1 in IDLE -> no state change; start during UP -> ignored, captured bounds unchanged.
